// File: rtl/mbf_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module   : mbf_cfg_loader
// Purpose  : Streams a host-written config buffer into the MBF config port.
// Revision : 1.0 - initial release
// ============================================================================
module mbf_cfg_loader #(
    parameter int CFG_DATA_WIDTH = 24,
    parameter int CFG_MAX_WORDS  = 35,
    parameter int ADDR_WIDTH     = 6,
    parameter int ACK_TIMEOUT    = 1023,
    parameter int TO_WIDTH       = 16
) (
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic                      Host_Wr_En,
    input  logic [ADDR_WIDTH-1:0]     Host_Wr_Addr,
    input  logic [CFG_DATA_WIDTH-1:0] Host_Wr_Data,
    input  logic                      Host_Start,
    input  logic [ADDR_WIDTH-1:0]     Host_Len,
    output logic                      Busy,
    output logic                      Load_Done,
    output logic                      Load_Err,
    output logic                      isConfig,
    output logic [CFG_DATA_WIDTH-1:0] Data_Config_Out,
    input  logic                      isConfigACK,
    input  logic                      isConfigDone
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_SEND      = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] MAX_LEN = ADDR_WIDTH'(CFG_MAX_WORDS);
    localparam logic [TO_WIDTH-1:0]   TO_LAST = TO_WIDTH'(ACK_TIMEOUT - 1);

    logic [CFG_DATA_WIDTH-1:0] r_mem [0:CFG_MAX_WORDS-1];

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH-1:0] r_last;
    logic [TO_WIDTH-1:0]   r_to_cnt;

    logic                  w_wr_ok;
    logic                  w_len_ok;
    logic                  w_ptr_last;
    logic                  w_to_hit;
    logic [ADDR_WIDTH-1:0] w_ptr_next;
    logic                  w_exit_ok;
    logic                  w_exit_err;

    assign w_wr_ok    = Host_Wr_En && (r_state == ST_IDLE) && (Host_Wr_Addr < MAX_LEN);
    assign w_len_ok   = (Host_Len != '0) && (Host_Len <= MAX_LEN);
    assign w_ptr_last = (r_ptr == r_last);
    assign w_to_hit   = (r_to_cnt == TO_LAST);
    assign w_ptr_next = r_ptr + ADDR_WIDTH'(1);

    // Buffer contents survive reset so the host need not rewrite after a recovery.
    always_ff @(posedge CLK) begin
        if (w_wr_ok) begin
            r_mem[Host_Wr_Addr] <= Host_Wr_Data;
        end
    end

    // Exit decisions; an ACK in the same cycle always beats the timeout.
    always_comb begin
        w_exit_ok  = 1'b0;
        w_exit_err = 1'b0;
        case (r_state)
            ST_SEND: begin
                if (isConfigDone) begin
                    if (isConfigACK && w_ptr_last) begin
                        w_exit_ok = 1'b1;
                    end else begin
                        w_exit_err = 1'b1;
                    end
                end else if (!isConfigACK && w_to_hit) begin
                    w_exit_err = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (isConfigDone) begin
                    w_exit_ok = 1'b1;
                end else if (w_to_hit) begin
                    w_exit_err = 1'b1;
                end
            end
            default: begin
                w_exit_ok  = 1'b0;
                w_exit_err = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state         <= ST_IDLE;
            r_ptr           <= '0;
            r_last          <= '0;
            r_to_cnt        <= '0;
            Busy            <= 1'b0;
            Load_Done       <= 1'b0;
            Load_Err        <= 1'b0;
            isConfig        <= 1'b0;
            Data_Config_Out <= '0;
        end else begin
            Load_Done <= 1'b0;
            Load_Err  <= 1'b0;
            if (w_exit_ok || w_exit_err) begin
                r_state         <= ST_IDLE;
                r_ptr           <= '0;
                r_to_cnt        <= '0;
                Busy            <= 1'b0;
                isConfig        <= 1'b0;
                Data_Config_Out <= '0;
                Load_Done       <= w_exit_ok;
                Load_Err        <= w_exit_err;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (Host_Start) begin
                            if (w_len_ok) begin
                                r_state         <= ST_SEND;
                                r_ptr           <= '0;
                                r_last          <= Host_Len - ADDR_WIDTH'(1);
                                r_to_cnt        <= '0;
                                Busy            <= 1'b1;
                                isConfig        <= 1'b1;
                                Data_Config_Out <= r_mem[0];
                            end else begin
                                Load_Err <= 1'b1;
                            end
                        end
                    end
                    ST_SEND: begin
                        if (isConfigACK) begin
                            r_to_cnt <= '0;
                            if (w_ptr_last) begin
                                r_state <= ST_WAIT_DONE;
                            end else begin
                                r_ptr           <= w_ptr_next;
                                Data_Config_Out <= r_mem[w_ptr_next];
                            end
                        end else begin
                            r_to_cnt <= r_to_cnt + TO_WIDTH'(1);
                        end
                    end
                    ST_WAIT_DONE: begin
                        r_to_cnt <= r_to_cnt + TO_WIDTH'(1);
                    end
                    default: begin
                        r_state         <= ST_IDLE;
                        Busy            <= 1'b0;
                        isConfig        <= 1'b0;
                        Data_Config_Out <= '0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/mbf_cfg_loader.md
Name: mbf_cfg_loader

Overview:
- Configuration initiator for the multichannel half-band/decimation filter stage (MBF).
- Holds a host-written buffer of config words: FIR coefficients, output-scale word, decimation factor.
- Streams the words into the filter stage's isConfig / isConfigACK / isConfigDone / Data_Config_In responder interface, one word per ACK.
- Sits between the host register bank and the MBF instance. Reports completion, timeout and protocol errors back to the host.

Parameters:
- CFG_DATA_WIDTH, 24, width of one config word (matches filter COEFF_WIDTH).
- CFG_MAX_WORDS, 35, buffer depth (FILTER_MAX_ORDER 32 + 3).
- ADDR_WIDTH, 6, buffer address / length width; 2^ADDR_WIDTH >= CFG_MAX_WORDS+1.
- ACK_TIMEOUT, 1023, max cycles waited for ACK or Done before error.
- TO_WIDTH, 16, timeout counter width.

Ports:
- CLK  in  1  clock.
- nRST  in  1  asynchronous active-low reset.
- Host_Wr_En  in  1  buffer write strobe.
- Host_Wr_Addr  in  ADDR_WIDTH  buffer write address.
- Host_Wr_Data  in  CFG_DATA_WIDTH  buffer write data.
- Host_Start  in  1  single-cycle load request.
- Host_Len  in  ADDR_WIDTH  number of words to send.
- Busy  out  1  high while a load is in progress.
- Load_Done  out  1  one-cycle pulse on successful completion.
- Load_Err  out  1  one-cycle pulse on bad length, timeout or early Done.
- isConfig  out  1  config session active, to MBF.
- Data_Config_Out  out  CFG_DATA_WIDTH  current config word, to MBF Data_Config_In.
- isConfigACK  in  1  MBF accepted current word (one-cycle pulse).
- isConfigDone  in  1  MBF finished applying config (level).

Behaviour:
- One clock (CLK); nRST is asynchronous, active-low.
- On reset, all outputs are 0, state is IDLE, word pointer is 0 and the timeout counter is 0. Buffer contents are not reset.
- A reset mid-load drops isConfig immediately (asynchronously). No Load_Done or Load_Err is issued.
- Host writes:
  - Accepted in IDLE when Host_Wr_Addr < CFG_MAX_WORDS; otherwise ignored.
  - Ignored while Busy.
- States: IDLE, SEND, WAIT_DONE.
- IDLE:
  - Host_Start with 1 <= Host_Len <= CFG_MAX_WORDS: latch len, ptr=0, go to SEND. Next cycle, isConfig=1, Busy=1, Data_Config_Out=buf[0].
  - Host_Start with Host_Len = 0 or > CFG_MAX_WORDS: Load_Err pulses the next cycle; stay in IDLE.
- SEND:
  - Data_Config_Out is held stable until isConfigACK is sampled high.
  - On ACK with ptr < len-1: ptr++ and Data_Config_Out=buf[ptr+1] on the next cycle.
  - Back-to-back ACKs give one word per cycle.
  - On ACK with ptr = len-1: go to WAIT_DONE; Data_Config_Out holds the last word.
- WAIT_DONE: isConfig stays 1 until isConfigDone is sampled high. Next cycle: isConfig=0, Busy=0, Load_Done=1 for one cycle, Data_Config_Out=0, IDLE.
- isConfigDone sampled high in SEND (early Done) is an error exit.
- ACK sampled outside SEND is ignored.
- Timeout counter:
  - Cleared on entering SEND or WAIT_DONE and on every ACK; increments otherwise while Busy.
  - Reaching ACK_TIMEOUT is an error exit.
- Error exit, next cycle: isConfig=0, Busy=0, Load_Err=1 for one cycle, Data_Config_Out=0, IDLE.
- Host_Start while Busy is ignored.
- If ACK and the timeout terminal count occur in the same cycle, ACK wins.
- If ACK and isConfigDone occur in the same SEND cycle on the last word, this counts as success: Load_Done next cycle, no WAIT_DONE dwell.
- Latency: Host_Start at cycle N gives isConfig high at N+1. Minimum load of L words with ACK every cycle and Done immediately: Load_Done at N+L+2.

Test Plan:
- Write buf[0..34]=0x000100+i, Start with Len=35, responder ACKs every cycle, Done 3 cycles after last ACK -> Data_Config_Out sequence 0x000100..0x000122 in order, isConfig high for exactly 35+4 cycles, one Load_Done pulse, Load_Err never.
- Len=3, responder ACKs with 5-cycle gaps -> each word held stable for all 6 cycles; no duplicated or skipped words.
- Start with Len=0, then with Len=36 -> Load_Err pulses once each; isConfig and Busy stay 0.
- Len=4, responder stops ACKing after word 1 -> Load_Err exactly ACK_TIMEOUT cycles after last ACK; isConfig drops; a subsequent good load then succeeds.
- isConfigDone asserted after the 2nd of 5 ACKs -> Load_Err, no Load_Done; Host_Start and Host_Wr_En while Busy have no effect (buffer readback unchanged).
- nRST pulsed low during SEND -> isConfig=0 asynchronously, all outputs 0, no pulses; restart with Len=2 completes normally.
